ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised multicycle control sequencer for the CPU datapath: owns the control state register, decodes the opcode class, and drives the datapath enables. It generalises the combinational state/opcode control decode with configurable opcode width and encodings, a latched opcode class, a memory ready/wait handshake, and retired-instruction and cycle counters. It sits between the instruction register and every datapath mux and write enable.

## Interface
- `OPCODE_W`, 6: opcode width.
- `OP_LD`, 6'h20: load opcode.
- `OP_STR`, 6'h28: store opcode.
- `OP_BEQ`, 6'h04: branch-equal opcode.
- `OP_JUMP`, 6'h02: jump opcode.
- `OP_LDI`, 6'h3F: load-immediate (immediate injection) opcode.
- `OP_RTYPE`, 6'h00: R-type opcode.
- `RI_CLASS`, 3'b001: opcode[OPCODE_W-1 -: 3] value marking an ALU register-immediate instruction.
- `CNT_W`, 32: counter width.

Ports:
- `clk` in 1: clock. One clock only.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in OPCODE_W: instruction-register opcode field. Sampled in DECODE only.
- `zero` in 1: ALU zero flag. Used by the branch unit, not by this block.
- `mem_ready` in 1: memory completion.
- `state` out 4: current state.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `mem_to_reg`, `reg_dst`, `alu_src_a`, `imm_inject`: each out 1, datapath enables and selects.
- `alu_src_b` out 2, `alu_op` out 2, `pc_source` out 2: datapath mux selects.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: one-cycle pulse on an unknown opcode.
- `instr_count`, `cycle_count` out CNT_W: retired instructions and cycles since reset.

## Operation
- State encodings: FETCH=0, DECODE=1, IMM3=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BRANCH3=6, MEMREF3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11. Codes 12–15 go to FETCH on the next cycle and pulse `illegal_op`.
- Outputs are Moore, decoded from `state` and the latched class. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` are 1 only in the completing cycle. Next state is DECODE.
- DECODE: `alu_src_b`=11, `alu_op`=00. Latch the opcode class. Next state by class:
  - LDI → IMM3
  - RTYPE → ALU_R3
  - RI → ALU_RI3
  - BEQ → BRANCH3
  - LD or STR → MEMREF3
  - JUMP → JUMP3
  - anything else → FETCH with an `illegal_op` pulse; counters not incremented.
- OP_LDI matches before the RI_CLASS test.
- IMM3: `reg_write`=1, `imm_inject`=1. Retire.
- ALU_R3: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state ALU4.
- ALU_RI3: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next state ALU4.
- ALU4: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=1 if the latched class is RTYPE, else 0. Retire.
- BRANCH3: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Retire.
- MEMREF3: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state LOAD4 for a load, STORE4 for a store.
- LOAD4: `mem_read`=1, `i_or_d`=1. Next state LOAD5 on completion.
- STORE4: `mem_write`=1, `i_or_d`=1. Retire on completion.
- LOAD5: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Retire.
- JUMP3: `pc_write`=1, `pc_source`=10. Retire.
- Retire means: `instr_done`=1 for that cycle, `instr_count`+1, next state FETCH.
- Counters wrap modulo 2^CNT_W. `cycle_count` increments every non-reset cycle.

## Timing
- Reset, checked each clock edge:
  - Registered state returns to FETCH, counters to 0, latched class to RTYPE.
  - While `reset`=1, all outputs except `state` and the counters are forced to 0, and `state` reads 0.
  - Reset mid-instruction abandons the instruction and leaves the counters at 0.
- Cycles per instruction with no wait states:
  - LDI, BEQ, JUMP: 3
  - R-type, RI, STR: 4
  - LD: 5
- `instr_done` asserts in the final cycle of the instruction; FETCH follows on the next cycle.
- Memory states are FETCH, LOAD4 and STORE4. A memory state "completes" when `mem_ready`=1 is sampled in it. Each additional wait cycle extends the instruction by 1.
- While waiting, the state holds; `mem_read`/`mem_write` and `i_or_d` stay stable; `ir_write`, `pc_write` and `instr_done` stay 0.

## Configuration
- `CTRL_MEM_HANDSHAKE_EN` defined: memory states wait for `mem_ready` as described in Timing.
- Not defined: `mem_ready` is ignored. Every memory state completes in one cycle, and `ir_write`/`pc_write` are 1 for the whole FETCH cycle.

## Test plan
- Reset: hold `reset` 2 cycles, then release with `mem_ready`=1 → `state`=0, both counters 0, all strobes 0 during reset. The first FETCH cycle after release shows `mem_read`=1.
- ADD (`opcode`=0x00), `mem_ready`=1 → states 0,1,3,5. ALU4 shows `reg_write`=1, `reg_dst`=1. `instr_done` pulses once and `instr_count`=1 after 4 cycles.
- LD (0x20) then STR (0x28) with `mem_ready` low for 2 cycles in LOAD4 (handshake on):
  - LD: LOAD4 lasts 3 cycles, LD retires after 7 cycles, LOAD5 shows `mem_to_reg`=1.
  - STR: sequence 0,1,7,9, STORE4 shows `mem_write`=1, `instr_count`=2.
- BEQ (0x04) → 3 cycles; BRANCH3 shows `pc_write_cond`=1, `pc_source`=01, `alu_op`=01.
- JUMP (0x02), LDI (0x3F), ADDI (0x08) → JUMP3 shows `pc_source`=10; IMM3 shows `imm_inject`=1; ADDI goes 0,1,4,5 with `reg_dst`=0.
- Opcode 0x3A → `illegal_op` pulses in DECODE, next state is FETCH, `instr_count` unchanged. Separately, assert reset during LOAD4 → `state`=0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multicycle control sequencer for the CPU datapath.
// Holds the control state register, decodes the instruction class in
// DECODE, latches it for later states, and drives all datapath enables and
// mux selects from the current state. Also keeps retired-instruction and
// cycle counters.
//
// Optional feature macro: CTRL_MEM_HANDSHAKE_EN
//   defined   : FETCH, LOAD4 and STORE4 hold until mem_ready is sampled high.
//   undefined : mem_ready is ignored and every memory state takes one cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   opcode            instruction-register opcode field (used in DECODE only)
//   zero              ALU zero flag (consumed by the branch unit, unused here)
//   mem_ready         memory completion
//   state             current state code (reads 0 while reset is high)
//   pc_write .. imm_inject, alu_src_b, alu_op, pc_source
//                     datapath enables and mux selects
//   instr_done        one-cycle pulse in the retiring cycle
//   illegal_op        one-cycle pulse on an unknown opcode
//   instr_count       retired instructions since reset
//   cycle_count       cycles since reset
module ctrl_sequencer #(
  parameter int unsigned           OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0]   OP_LD    = OPCODE_W'(6'h20),
  parameter logic [OPCODE_W-1:0]   OP_STR   = OPCODE_W'(6'h28),
  parameter logic [OPCODE_W-1:0]   OP_BEQ   = OPCODE_W'(6'h04),
  parameter logic [OPCODE_W-1:0]   OP_JUMP  = OPCODE_W'(6'h02),
  parameter logic [OPCODE_W-1:0]   OP_LDI   = OPCODE_W'(6'h3F),
  parameter logic [OPCODE_W-1:0]   OP_RTYPE = OPCODE_W'(6'h00),
  parameter logic [2:0]            RI_CLASS = 3'b001,
  parameter int unsigned           CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [3:0]          state,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic                imm_inject,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_IMM3    = 4'd2,
    S_ALU_R3  = 4'd3,
    S_ALU_RI3 = 4'd4,
    S_ALU4    = 4'd5,
    S_BRANCH3 = 4'd6,
    S_MEMREF3 = 4'd7,
    S_LOAD4   = 4'd8,
    S_STORE4  = 4'd9,
    S_LOAD5   = 4'd10,
    S_JUMP3   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_RI    = 3'd1,
    C_LDI   = 3'd2,
    C_BEQ   = 3'd3,
    C_LD    = 3'd4,
    C_STR   = 3'd5,
    C_JUMP  = 3'd6,
    C_ILL   = 3'd7
  } iclass_t;

  state_t  state_q, state_d;
  iclass_t cls_q;
  iclass_t dec_class;
  logic    mem_done;

  // Inputs this block deliberately does not consume in every build.
  logic unused_inputs;
  assign unused_inputs = ^{zero, mem_ready};

  // A memory state completes when the memory reports ready, or always when
  // the handshake is compiled out.
`ifdef CTRL_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // Opcode class decode; LDI is matched before the RI class field so an
  // LDI encoding inside the RI group is still an immediate load.
  always_comb begin
    dec_class = C_ILL;
    if (opcode == OP_LDI)
      dec_class = C_LDI;
    else if (opcode == OP_RTYPE)
      dec_class = C_RTYPE;
    else if (opcode[OPCODE_W-1 -: 3] == RI_CLASS)
      dec_class = C_RI;
    else if (opcode == OP_BEQ)
      dec_class = C_BEQ;
    else if (opcode == OP_LD)
      dec_class = C_LD;
    else if (opcode == OP_STR)
      dec_class = C_STR;
    else if (opcode == OP_JUMP)
      dec_class = C_JUMP;
  end

  // State register and latched instruction class.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_RTYPE;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        cls_q <= dec_class;
    end
  end

  // Next-state and control decode; everything is held at 0 during reset.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    imm_inject    = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          // IR load and PC increment only in the cycle the fetch completes.
          if (mem_done) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (dec_class)
            C_LDI:        state_d = S_IMM3;
            C_RTYPE:      state_d = S_ALU_R3;
            C_RI:         state_d = S_ALU_RI3;
            C_BEQ:        state_d = S_BRANCH3;
            C_LD, C_STR:  state_d = S_MEMREF3;
            C_JUMP:       state_d = S_JUMP3;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_IMM3: begin
          reg_write  = 1'b1;
          imm_inject = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ALU_R3: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_ALU4;
        end
        S_ALU_RI3: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          state_d   = S_ALU4;
        end
        S_ALU4: begin
          reg_write  = 1'b1;
          reg_dst    = (cls_q == C_RTYPE);
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH3: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_MEMREF3: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (cls_q == C_STR) ? S_STORE4 : S_LOAD4;
        end
        S_LOAD4: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_done)
            state_d = S_LOAD5;
        end
        S_STORE4: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_done) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_LOAD5: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP3: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: begin
          // Unused codes recover to FETCH and flag the event.
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      endcase
    end
  end

  assign state = reset ? 4'd0 : state_q;

  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (instr_done)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
